// File: rtl/ex_muldiv.sv
// RV32M multiply/divide unit for the EX stage: iterative shift-add multiplier and restoring divider.
// Build option: define EX_MULDIV_FAST_MUL_EN for single-cycle combinational multiplies.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            idex_md_valid_i,
  input  logic [2:0]      idex_md_op_i,
  input  logic [XLEN-1:0] idex_op_a_i,
  input  logic [XLEN-1:0] idex_op_b_i,
  input  logic [4:0]      idex_reg_waddr_i,
  input  logic            fc_flush_ex_i,
  input  logic            fc_stall_ex_i,
  output logic            ex_md_busy_o,
  output logic            ex_md_valid_o,
  output logic [XLEN-1:0] ex_md_result_o,
  output logic [4:0]      ex_md_waddr_o
);

  localparam logic [2:0]      OP_MUL    = 3'd0;
  localparam logic [2:0]      OP_MULHSU = 3'd2;
  localparam logic [2:0]      OP_MULHU  = 3'd3;
  localparam logic [2:0]      OP_DIVU   = 3'd5;
  localparam logic [2:0]      OP_REMU   = 3'd7;
  localparam logic [XLEN-1:0] CNT_LAST  = XLEN'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e              state_q;
  logic [2:0]          op_q;
  logic [4:0]          waddr_q;
  logic [4:0]          out_waddr_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     b_q;
  logic [XLEN-1:0]     cnt_q;
  logic [XLEN-1:0]     result_q;
  logic                neg_q;
  logic                valid_q;

  // Accept-time decode, working on the raw ID/EX operands.
  logic                accept;
  logic                is_div;
  logic                a_sgn;
  logic                b_sgn;
  logic                neg_d;
  logic                div_zero;
  logic                div_ovf;
  logic                special;
  logic                fast_mul;
  logic [XLEN-1:0]     a_abs;
  logic [XLEN-1:0]     b_abs;
  logic [XLEN-1:0]     special_res;
  logic [XLEN-1:0]     fast_res;

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    is_div   = idex_md_op_i[2];
    a_sgn    = idex_op_a_i[XLEN-1] && !(idex_md_op_i inside {OP_MULHU, OP_DIVU, OP_REMU});
    b_sgn    = idex_op_b_i[XLEN-1] &&
               !(idex_md_op_i inside {OP_MULHSU, OP_MULHU, OP_DIVU, OP_REMU});
    a_abs    = a_sgn ? -idex_op_a_i : idex_op_a_i;
    b_abs    = b_sgn ? -idex_op_b_i : idex_op_b_i;
    // Remainder takes the dividend's sign; quotient and products take the XOR.
    neg_d    = (is_div && idex_md_op_i[1]) ? a_sgn : (a_sgn ^ b_sgn);
    div_zero = is_div && (idex_op_b_i == '0);
    div_ovf  = is_div && !idex_md_op_i[0] && (idex_op_a_i == MOST_NEG) && (idex_op_b_i == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = idex_md_op_i[1] ? idex_op_a_i : '1;
    else          special_res = idex_md_op_i[1] ? '0 : idex_op_a_i;
  end

`ifdef EX_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a;
  logic [2*XLEN-1:0] fast_b;
  logic [2*XLEN-1:0] fast_prod;

  // Sign-extending to 2*XLEN makes the truncated product equal the signed/unsigned product.
  always_comb begin
    fast_a    = {{XLEN{a_sgn}}, idex_op_a_i};
    fast_b    = {{XLEN{b_sgn}}, idex_op_b_i};
    fast_prod = fast_a * fast_b;
    fast_res  = (idex_md_op_i == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end

  assign fast_mul = !is_div;
`else
  assign fast_mul = 1'b0;
  assign fast_res = '0;
`endif

  assign accept       = (state_q == S_IDLE) && idex_md_valid_i && !fc_flush_ex_i;
  assign ex_md_busy_o = accept || (state_q == S_CALC);

  // One engine step; acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       rem_sh;
  logic                div_ge;
  logic [XLEN-1:0]     rem_new;
  logic [XLEN-1:0]     div_res;
  logic [2*XLEN-1:0]   acc_d;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     calc_res;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc_q[0]}} & b_q};
    rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge  = rem_sh[XLEN] || (rem_sh[XLEN-1:0] >= b_q);
    rem_new = div_ge ? (rem_sh[XLEN-1:0] - b_q) : rem_sh[XLEN-1:0];
    acc_d   = op_q[2] ? {rem_new, acc_q[XLEN-2:0], div_ge}
                      : {mul_sum, acc_q[XLEN-1:1]};
    prod    = neg_q ? -acc_d : acc_d;
    div_res = op_q[1] ? acc_d[2*XLEN-1:XLEN] : acc_d[XLEN-1:0];
    if (op_q[2])              calc_res = neg_q ? -div_res : div_res;
    else if (op_q == OP_MUL)  calc_res = prod[XLEN-1:0];
    else                      calc_res = prod[2*XLEN-1:XLEN];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      waddr_q     <= '0;
      out_waddr_q <= '0;
      acc_q       <= '0;
      b_q         <= '0;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
    end else if (fc_flush_ex_i) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (idex_md_valid_i) begin
            op_q    <= idex_md_op_i;
            waddr_q <= idex_reg_waddr_i;
            acc_q   <= {{XLEN{1'b0}}, a_abs};
            b_q     <= b_abs;
            neg_q   <= neg_d;
            cnt_q   <= '0;
            if (special || fast_mul) begin
              result_q    <= special ? special_res : fast_res;
              out_waddr_q <= idex_reg_waddr_i;
              valid_q     <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_q       <= '0;
            result_q    <= calc_res;
            out_waddr_q <= waddr_q;
            valid_q     <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (!fc_stall_ex_i) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ex_md_valid_o  = valid_q;
  assign ex_md_result_o = result_q;
  assign ex_md_waddr_o  = out_waddr_q;

endmodule
